line_cmd_queue: RTL and testbench

- Command FIFO and issue sequencer directly upstream of the line drawer.
- Buffers line commands {x0, y0, x1, y1, color} pushed by the host/CPU side.
- Feeds commands one at a time to the drawer's x0/y0/x1/y1/color_in/start inputs, using the drawer's busy output as the completion handshake.
- Holds drawer operands stable for the whole draw.

---
 rtl/line_cmd_queue.sv | 151 +++++++++++++++
 tb/tb_line_cmd_queue.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_cmd_queue.sv
// Line command queue: buffers {x0,y0,x1,y1,color} commands from the host and
// issues them one at a time to the line drawer. It uses the drawer's busy
// output as the completion handshake.
module line_cmd_queue #(
  parameter int WIDTH_BITS = 6,
  parameter int COLOR_BITS = 8,
  parameter int DEPTH_BITS = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic signed [WIDTH_BITS:0]   in_x0,
  input  logic signed [WIDTH_BITS:0]   in_y0,
  input  logic signed [WIDTH_BITS:0]   in_x1,
  input  logic signed [WIDTH_BITS:0]   in_y1,
  input  logic        [COLOR_BITS-1:0] in_color,
  output logic                         full,
  output logic        [DEPTH_BITS:0]   level,
  output logic                         overflow,
  output logic signed [WIDTH_BITS:0]   x0,
  output logic signed [WIDTH_BITS:0]   y0,
  output logic signed [WIDTH_BITS:0]   x1,
  output logic signed [WIDTH_BITS:0]   y1,
  output logic        [COLOR_BITS-1:0] color,
  output logic                         start,
  input  logic                         line_busy,
  output logic        [15:0]           lines_done,
  output logic                         idle
);

  localparam int CW    = WIDTH_BITS + 1;
  localparam int EW    = 4 * CW + COLOR_BITS;
  localparam int DEPTH = 2 ** DEPTH_BITS;
  localparam logic [DEPTH_BITS:0] LEVEL_FULL = {1'b1, {DEPTH_BITS{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_BUSY,
    S_WAIT_DONE
  } state_t;

  state_t                  state_q;
  logic [EW-1:0]           mem_q [DEPTH];
  logic [DEPTH_BITS-1:0]   wr_ptr_q;
  logic [DEPTH_BITS-1:0]   rd_ptr_q;
  logic [DEPTH_BITS:0]     level_q;
  logic [DEPTH_BITS:0]     level_d;
  logic                    overflow_q;
  logic signed [WIDTH_BITS:0] x0_q, y0_q, x1_q, y1_q;
  logic [COLOR_BITS-1:0]   color_q;
  logic                    start_q;
  logic [15:0]             lines_done_q;
  logic                    push_ok;
  logic                    pop;
  logic [EW-1:0]           head;

  // Accept/pop decisions come from registered state only, so nothing falls through.
  always_comb begin
    full    = (level_q == LEVEL_FULL);
    push_ok = push && !full;
    pop     = (state_q == S_IDLE) && (level_q != '0) && !line_busy;
    head    = mem_q[rd_ptr_q];
    level_d = level_q;
    if (push_ok && !pop) begin
      level_d = level_q + 1'b1;
    end else if (!push_ok && pop) begin
      level_d = level_q - 1'b1;
    end
  end

  // FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      level_q <= level_d;
      if (push && full) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // Entry storage; contents need no reset because the pointers gate every read.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= {in_x0, in_y0, in_x1, in_y1, in_color};
    end
  end

  // Issue sequencer: pop, pulse start, then follow the drawer's busy rise and fall.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      x0_q         <= '0;
      y0_q         <= '0;
      x1_q         <= '0;
      y1_q         <= '0;
      color_q      <= '0;
      start_q      <= 1'b0;
      lines_done_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pop) begin
            {x0_q, y0_q, x1_q, y1_q, color_q} <= head;
            start_q <= 1'b1;
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          start_q <= 1'b0;
          state_q <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          if (line_busy) begin
            state_q <= S_WAIT_DONE;
          end
        end
        S_WAIT_DONE: begin
          if (!line_busy) begin
            lines_done_q <= lines_done_q + 16'd1;
            state_q      <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign level      = level_q;
  assign overflow   = overflow_q;
  assign x0         = x0_q;
  assign y0         = y0_q;
  assign x1         = x1_q;
  assign y1         = y1_q;
  assign color      = color_q;
  assign start      = start_q;
  assign lines_done = lines_done_q;
  assign idle       = (state_q == S_IDLE) && (level_q == '0) && !line_busy;

endmodule

// File: tb/tb_line_cmd_queue.sv
// Testbench for line_cmd_queue: directed scenarios plus a randomized run
// checked against a queue-based reference model and a behavioural drawer.
module tb_line_cmd_queue;
  localparam int WB = 6;
  localparam int CB = 8;
  localparam int DB = 4;

  typedef struct packed {
    logic [WB:0]   x0;
    logic [WB:0]   y0;
    logic [WB:0]   x1;
    logic [WB:0]   y1;
    logic [CB-1:0] c;
  } cmd_t;

  logic clk = 1'b0;
  logic reset, push, line_busy;
  logic signed [WB:0] in_x0, in_y0, in_x1, in_y1;
  logic [CB-1:0] in_color;
  logic full, overflow, start, idle;
  logic [DB:0] level;
  logic signed [WB:0] x0, y0, x1, y1;
  logic [CB-1:0] color;
  logic [15:0] lines_done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // behavioural drawer state
  bit drw_en;
  bit drw_pending;
  int drw_left;
  int drw_falls;
  int fall_cyc;

  line_cmd_queue #(.WIDTH_BITS(WB), .COLOR_BITS(CB), .DEPTH_BITS(DB)) dut (
    .clk(clk), .reset(reset), .push(push),
    .in_x0(in_x0), .in_y0(in_y0), .in_x1(in_x1), .in_y1(in_y1), .in_color(in_color),
    .full(full), .level(level), .overflow(overflow),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1), .color(color), .start(start),
    .line_busy(line_busy), .lines_done(lines_done), .idle(idle)
  );

  always #5 clk = ~clk;

  function automatic cmd_t mk(int a, int b, int c, int d, int col);
    cmd_t r;
    r.x0 = 7'(a); r.y0 = 7'(b); r.x1 = 7'(c); r.y1 = 7'(d); r.c = 8'(col);
    return r;
  endfunction

  function automatic cmd_t rnd_cmd();
    cmd_t r;
    r.x0 = 7'($urandom); r.y0 = 7'($urandom); r.x1 = 7'($urandom); r.y1 = 7'($urandom);
    r.c = 8'($urandom);
    return r;
  endfunction

  function automatic cmd_t ops();
    cmd_t r;
    r = {x0, y0, x1, y1, color};
    return r;
  endfunction

  task automatic drive_cmd(input cmd_t c);
    in_x0 = c.x0; in_y0 = c.y0; in_x1 = c.x1; in_y1 = c.y1; in_color = c.c;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Drawer: latches on the edge after start is seen, stays busy 1..6 cycles.
  task automatic drw_step();
    if (drw_en) begin
      if (drw_left > 0) begin
        drw_left--;
        if (drw_left == 0) begin
          line_busy = 1'b0;
          drw_falls++;
          fall_cyc = cyc;
        end
      end
      if (drw_pending) begin
        line_busy   = 1'b1;
        drw_left    = $urandom_range(1, 6);
        drw_pending = 1'b0;
      end
      if (start) drw_pending = 1'b1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; push = 1'b0; line_busy = 1'b0;
    drw_en = 1'b0; drw_pending = 1'b0; drw_left = 0; drw_falls = 0; fall_cyc = -1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (level !== 5'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", level); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %0b exp 0", full); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %0b exp 0", overflow); end
    checks++; if (start !== 1'b0) begin errors++; $display("FAIL reset_start got %0b exp 0", start); end
    checks++; if (ops() !== '0) begin errors++; $display("FAIL reset_operands got %h exp 0", ops()); end
    checks++; if (lines_done !== 16'd0) begin errors++; $display("FAIL reset_lines_done got %0d exp 0", lines_done); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL reset_idle got %0b exp 1", idle); end
  endtask

  task automatic test_single();
    cmd_t c;
    int base, nst, k;
    bit started;
    do_reset();
    drw_en = 1'b1;
    c = mk(0, 0, 5, 3, 8'hA5);
    drive_cmd(c);
    base = cyc; nst = 0; started = 1'b0;
    push = 1'b1;
    for (k = 0; k < 60; k++) begin
      tick();
      push = 1'b0;
      drw_step();
      if (start) begin
        nst++;
        checks++; if (cyc - base !== 2) begin errors++; $display("FAIL single_start_latency got %0d exp 2", cyc - base); end
        started = 1'b1;
      end
      if (started) begin
        checks++; if (ops() !== c) begin errors++; $display("FAIL single_operands got %h exp %h", ops(), c); end
      end
      if (started && idle) break;
    end
    checks++; if (nst !== 1) begin errors++; $display("FAIL single_start_count got %0d exp 1", nst); end
    checks++; if (lines_done !== 16'd1) begin errors++; $display("FAIL single_lines_done got %0d exp 1", lines_done); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL single_idle got %0b exp 1", idle); end
  endtask

  task automatic test_back_to_back();
    cmd_t cmds[3];
    cmd_t cur;
    int base, nst, k;
    cmds[0] = mk(3, -1, -3, 1, 8'h5C);
    cmds[1] = mk(-4, 2, 4, -2, 8'h11);
    cmds[2] = mk(10, 10, 10, 10, 8'hF0);
    do_reset();
    drw_en = 1'b1;
    base = cyc; nst = 0; cur = '0;
    for (k = 0; k < 200; k++) begin
      if (k < 3) begin drive_cmd(cmds[k]); push = 1'b1; end
      else push = 1'b0;
      tick();
      drw_step();
      if (start) begin
        if (nst < 3) begin
          checks++; if (ops() !== cmds[nst]) begin errors++; $display("FAIL b2b_order got %h exp %h", ops(), cmds[nst]); end
          if (nst == 0) begin
            checks++; if (cyc - base !== 2) begin errors++; $display("FAIL b2b_first_latency got %0d exp 2", cyc - base); end
          end else begin
            checks++; if (cyc - fall_cyc !== 2) begin errors++; $display("FAIL b2b_gap got %0d exp 2", cyc - fall_cyc); end
          end
          cur = cmds[nst];
        end
        nst++;
      end
      if (line_busy) begin
        checks++; if (ops() !== cur) begin errors++; $display("FAIL b2b_stable got %h exp %h", ops(), cur); end
      end
      if (nst == 3 && idle) break;
    end
    checks++; if (nst !== 3) begin errors++; $display("FAIL b2b_start_count got %0d exp 3", nst); end
    checks++; if (lines_done !== 16'd3) begin errors++; $display("FAIL b2b_lines_done got %0d exp 3", lines_done); end
  endtask

  task automatic test_overflow17();
    do_reset();
    line_busy = 1'b1;
    for (int i = 0; i < 17; i++) begin
      drive_cmd(rnd_cmd());
      push = 1'b1;
      tick();
      checks++; if (level !== 5'((i < 16) ? i + 1 : 16)) begin errors++; $display("FAIL ovf_level got %0d exp %0d", level, (i < 16) ? i + 1 : 16); end
      checks++; if (full !== (i >= 15)) begin errors++; $display("FAIL ovf_full got %0b exp %0b", full, i >= 15); end
      checks++; if (overflow !== (i == 16)) begin errors++; $display("FAIL ovf_flag got %0b exp %0b", overflow, i == 16); end
      checks++; if (start !== 1'b0) begin errors++; $display("FAIL ovf_no_start got %0b exp 0", start); end
    end
    push = 1'b0;
    tick(); tick(); tick();
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %0b exp 1", overflow); end
    checks++; if (level !== 5'd16) begin errors++; $display("FAIL ovf_level_hold got %0d exp 16", level); end
  endtask

  task automatic test_full_pop();
    cmd_t first, c;
    do_reset();
    line_busy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      c = rnd_cmd();
      if (i == 0) first = c;
      drive_cmd(c);
      push = 1'b1;
      tick();
    end
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL fullpop_full got %0b exp 1", full); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fullpop_pre_ovf got %0b exp 0", overflow); end
    drive_cmd(rnd_cmd());
    push = 1'b1;
    line_busy = 1'b0;
    tick();
    push = 1'b0;
    line_busy = 1'b1;
    checks++; if (level !== 5'd15) begin errors++; $display("FAIL fullpop_level got %0d exp 15", level); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL fullpop_ovf got %0b exp 1", overflow); end
    checks++; if (start !== 1'b1) begin errors++; $display("FAIL fullpop_start got %0b exp 1", start); end
    checks++; if (ops() !== first) begin errors++; $display("FAIL fullpop_head got %h exp %h", ops(), first); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    line_busy = 1'b1;
    for (int i = 0; i < 7; i++) begin
      drive_cmd(rnd_cmd());
      push = 1'b1;
      tick();
    end
    push = 1'b0;
    line_busy = 1'b0; tick();
    line_busy = 1'b1; tick(); tick();
    line_busy = 1'b0; tick(); tick();
    line_busy = 1'b1; tick(); tick();
    checks++; if (lines_done !== 16'd1) begin errors++; $display("FAIL midrst_pre_lines got %0d exp 1", lines_done); end
    checks++; if (level !== 5'd5) begin errors++; $display("FAIL midrst_pre_level got %0d exp 5", level); end
    checks++; if (idle !== 1'b0) begin errors++; $display("FAIL midrst_pre_idle got %0b exp 0", idle); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (level !== 5'd0) begin errors++; $display("FAIL midrst_level got %0d exp 0", level); end
    checks++; if (start !== 1'b0) begin errors++; $display("FAIL midrst_start got %0b exp 0", start); end
    checks++; if (ops() !== '0) begin errors++; $display("FAIL midrst_operands got %h exp 0", ops()); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL midrst_ovf got %0b exp 0", overflow); end
    checks++; if (lines_done !== 16'd0) begin errors++; $display("FAIL midrst_lines got %0d exp 0", lines_done); end
    line_busy = 1'b0;
    #1;
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL midrst_idle got %0b exp 1", idle); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (start !== 1'b0 || level !== 5'd0) begin errors++; $display("FAIL midrst_quiet got start=%0b level=%0d exp 0/0", start, level); end
    end
  endtask

  task automatic test_hold_busy();
    cmd_t c;
    do_reset();
    line_busy = 1'b1;
    c = rnd_cmd();
    drive_cmd(c);
    push = 1'b1;
    tick();
    push = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (start !== 1'b0 || level !== 5'd1) begin errors++; $display("FAIL hold_blocked got start=%0b level=%0d exp 0/1", start, level); end
    end
    line_busy = 1'b0;
    tick();
    checks++; if (start !== 1'b1) begin errors++; $display("FAIL hold_release_start got %0b exp 1", start); end
    checks++; if (level !== 5'd0) begin errors++; $display("FAIL hold_release_level got %0d exp 0", level); end
    checks++; if (ops() !== c) begin errors++; $display("FAIL hold_operands got %h exp %h", ops(), c); end
  endtask

  task automatic test_random();
    cmd_t q[$];
    cmd_t c, cur;
    bit do_push, acc, exp_ovf, prev_start;
    int issued, k;
    do_reset();
    drw_en = 1'b1;
    exp_ovf = 1'b0; prev_start = 1'b0; issued = 0; cur = '0;
    for (k = 0; k < 3000; k++) begin
      do_push = (k < 600) && ($urandom_range(0, 99) < 45);
      c = rnd_cmd();
      drive_cmd(c);
      push = do_push;
      acc = do_push && (q.size() < 16);
      if (do_push && q.size() == 16) exp_ovf = 1'b1;
      tick();
      push = 1'b0;
      drw_step();
      if (start) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL rand_start_empty got start=1 exp no entry to issue");
        end else begin
          if (ops() !== q[0]) begin errors++; $display("FAIL rand_order got %h exp %h", ops(), q[0]); end
          cur = q.pop_front();
        end
        issued++;
        checks++; if (prev_start) begin errors++; $display("FAIL rand_start_width got 2+ cycles exp 1"); end
      end
      prev_start = start;
      if (acc) q.push_back(c);
      checks++; if (level !== 5'(q.size())) begin errors++; $display("FAIL rand_level got %0d exp %0d", level, q.size()); end
      checks++; if (full !== (q.size() == 16)) begin errors++; $display("FAIL rand_full got %0b exp %0b", full, q.size() == 16); end
      checks++; if (overflow !== exp_ovf) begin errors++; $display("FAIL rand_overflow got %0b exp %0b", overflow, exp_ovf); end
      if (line_busy) begin
        checks++; if (ops() !== cur) begin errors++; $display("FAIL rand_stable got %h exp %h", ops(), cur); end
      end
      if (k >= 600 && q.size() == 0 && idle) break;
    end
    checks++; if (k >= 3000) begin errors++; $display("FAIL rand_drain_timeout got busy exp idle"); end
    checks++; if (lines_done !== 16'(drw_falls)) begin errors++; $display("FAIL rand_lines_done got %0d exp %0d", lines_done, drw_falls); end
    checks++; if (drw_falls !== issued) begin errors++; $display("FAIL rand_completions got %0d exp %0d", drw_falls, issued); end
  endtask

  initial begin
    reset = 1'b1; push = 1'b0; line_busy = 1'b0;
    in_x0 = '0; in_y0 = '0; in_x1 = '0; in_y1 = '0; in_color = '0;
    drw_en = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow17();
    test_full_pop();
    test_reset_mid();
    test_hold_busy();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
